// File: rtl/prism_state_engine.sv
// prism_state_engine
//   Execution stage downstream of the PRISM State Information Table (SIT).
//   Holds the current state index and drives it as the SIT read address.
//   Every enabled cycle it decodes the returned SIT entry and evaluates one
//   condition, taken either from a synchronized input pin or from a counter
//   match. It then registers the next state, the output pins, the counter and
//   a one-cycle interrupt.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   en         run enable (level); held low while the SIT is reprogrammed
//   restart    one-cycle pulse, returns to state 0 and clears outputs/counter
//   in_pins    asynchronous condition inputs (2-flop synchronized)
//   sit_raddr  SIT read address, equal to the current state register
//   sit_rdata  SIT entry, combinational read of sit_raddr
//   out_pins   registered state-machine outputs
//   irq        one-cycle interrupt pulse per qualifying evaluation
//   count_out  current counter value
module prism_state_engine #(
  parameter int WIDTH  = 80,
  parameter int DEPTH  = 8,
  parameter int A_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [15:0]       in_pins,
  output logic [A_BITS-1:0] sit_raddr,
  input  logic [WIDTH-1:0]  sit_rdata,
  output logic [7:0]        out_pins,
  output logic              irq,
  output logic [15:0]       count_out
);

  // SIT entry layout, MSB first so that cond_sel lands in bits [3:0].
  typedef struct packed {
    logic        irq_en;      // [46]
    logic [15:0] cnt_match;   // [45:30]
    logic        cnt_inc;     // [29]
    logic        cnt_clr;     // [28]
    logic [7:0]  out_false;   // [27:20]
    logic [7:0]  out_true;    // [19:12]
    logic [2:0]  next_false;  // [11:9]
    logic [2:0]  next_true;   // [8:6]
    logic        cond_cnt;    // [5]
    logic        cond_inv;    // [4]
    logic [3:0]  cond_sel;    // [3:0]
  } sit_entry_t;

  sit_entry_t        entry;
  logic [15:0]       sync1_q, sync2_q;
  logic [A_BITS-1:0] state_q, state_d;
  logic [7:0]        out_q, out_d;
  logic              irq_q, irq_d;
  logic [15:0]       count_q, count_d;

  logic              cond;
  logic [2:0]        nxt_raw;
  logic [A_BITS-1:0] nxt_idx, nxt;

  // Entry bits above 46 carry no meaning for this stage.
  logic unused_bits;
  assign unused_bits = ^sit_rdata;

  assign entry = sit_entry_t'(sit_rdata[46:0]);

  // Condition and next-state decode of the current entry.
  always_comb begin
    cond    = (entry.cond_cnt ? (count_q == entry.cnt_match)
                              : sync2_q[entry.cond_sel]) ^ entry.cond_inv;
    nxt_raw = cond ? entry.next_true : entry.next_false;
    nxt_idx = nxt_raw[A_BITS-1:0];
    // Indices past the last programmed state fall back to state 0.
    nxt     = (32'(nxt_idx) >= DEPTH) ? '0 : nxt_idx;
  end

  // Next-value logic for all architectural state.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    state_d = state_q;
    out_d   = out_q;
    count_d = count_q;
    irq_d   = 1'b0;
    if (restart) begin
      state_d = '0;
      out_d   = '0;
      count_d = '0;
    end else if (en) begin
      state_d = nxt;
      out_d   = cond ? entry.out_true : entry.out_false;
      irq_d   = cond & entry.irq_en;
      // A self-loop never clears; increment saturates instead of wrapping.
      if (nxt != state_q && entry.cnt_clr)
        count_d = '0;
      else if (entry.cnt_inc && count_q != 16'hFFFF)
        count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= '0;
      out_q   <= '0;
      irq_q   <= 1'b0;
      count_q <= '0;
    end else begin
      // Synchronizer runs regardless of en/restart.
      sync1_q <= in_pins;
      sync2_q <= sync1_q;
      state_q <= state_d;
      out_q   <= out_d;
      irq_q   <= irq_d;
      count_q <= count_d;
    end
  end

  assign sit_raddr = state_q;
  assign out_pins  = out_q;
  assign irq       = irq_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_prism_state_engine.sv
// Testbench for prism_state_engine (DEPTH=5 so out-of-range indices exist).
// A cycle model pushes the expected outputs into a queue as each cycle's
// stimulus is applied; the entry is popped and compared after the edge.
module tb_prism_state_engine;

  localparam int TB_DEPTH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        restart = 1'b0;
  logic [15:0] in_pins = '0;
  logic [2:0]  sit_raddr;
  logic [79:0] sit_rdata;
  logic [7:0]  out_pins;
  logic        irq;
  logic [15:0] count_out;

  logic [79:0] sit [8];

  prism_state_engine #(.WIDTH(80), .DEPTH(TB_DEPTH), .A_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .in_pins   (in_pins),
    .sit_raddr (sit_raddr),
    .sit_rdata (sit_rdata),
    .out_pins  (out_pins),
    .irq       (irq),
    .count_out (count_out)
  );

  assign sit_rdata = sit[sit_raddr];

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  out;
    logic        irq;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [2:0]  m_st  = '0;
  logic [7:0]  m_out = '0;
  logic        m_irq = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_s1  = '0;
  logic [15:0] m_s2  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Builds an entry by bit position; bits 79:47 get random garbage.
  function automatic logic [79:0] ent(input logic [3:0] sel, input logic inv,
      input logic ccnt, input logic [2:0] nt, input logic [2:0] nf,
      input logic [7:0] ot, input logic [7:0] of, input logic clr,
      input logic inc, input logic [15:0] match, input logic ie);
    logic [79:0] e;
    e = '0;
    e[3:0]   = sel;
    e[4]     = inv;
    e[5]     = ccnt;
    e[8:6]   = nt;
    e[11:9]  = nf;
    e[19:12] = ot;
    e[27:20] = of;
    e[28]    = clr;
    e[29]    = inc;
    e[45:30] = match;
    e[46]    = ie;
    e[79:47] = {1'($urandom), $urandom};
    return e;
  endfunction

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [79:0] e;
    logic        c;
    logic [2:0]  nx;
    if (rst) begin
      m_st = '0; m_out = '0; m_irq = 1'b0; m_cnt = '0; m_s1 = '0; m_s2 = '0;
    end else begin
      if (restart) begin
        m_st = '0; m_out = '0; m_irq = 1'b0; m_cnt = '0;
      end else if (en) begin
        e  = sit[m_st];
        c  = (e[5] ? (m_cnt == e[45:30]) : m_s2[e[3:0]]) ^ e[4];
        nx = c ? e[8:6] : e[11:9];
        if (nx >= 3'(TB_DEPTH)) nx = '0;
        if (e[28] && nx != m_st) m_cnt = '0;
        else if (e[29] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_out = c ? e[19:12] : e[27:20];
        m_irq = c & e[46];
        m_st  = nx;
      end else begin
        m_irq = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = in_pins;
    end
  endtask

  task automatic step(input string tag);
    exp_t x;
    model_edge();
    x.st = m_st; x.out = m_out; x.irq = m_irq; x.cnt = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({tag, "_st"},  32'(sit_raddr), 32'(x.st));
    check({tag, "_out"}, 32'(out_pins),  32'(x.out));
    check({tag, "_irq"}, 32'(irq),       32'(x.irq));
    check({tag, "_cnt"}, 32'(count_out), 32'(x.cnt));
  endtask

  // Halts, clears the table and flushes the synchronizer with in_pins=0.
  task automatic setup();
    en = 1'b0;
    in_pins = '0;
    for (int i = 0; i < 8; i++) sit[i] = ent(4'd0, 1'b0, 1'b0, 3'd0, 3'd0,
                                             8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    step("setup");
    step("setup");
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    step("rs");
    restart = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sit[i] = '0;

    // Reset with en high and random pins.
    for (int i = 0; i < 2; i++) begin
      in_pins = 16'($urandom);
      step("reset");
      check("reset_st", 32'(sit_raddr), 32'd0);
      check("reset_out", 32'(out_pins), 32'd0);
    end
    rst = 1'b0;
    in_pins = 16'($urandom);
    step("post_reset");
    check("post_reset_st", 32'(sit_raddr), 32'd0);
    check("post_reset_cnt", 32'(count_out), 32'd0);
    check("post_reset_irq", 32'(irq), 32'd0);

    // Input branch with 3-edge latency.
    setup();
    sit[0] = ent(4'd3, 1'b0, 1'b0, 3'd1, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    sit[1] = ent(4'd3, 1'b1, 1'b0, 3'd0, 3'd1, 8'h3C, 8'h5A, 1'b0, 1'b0, 16'd0, 1'b0);
    restart_pulse();
    step("ib_idle");
    in_pins[3] = 1'b1;
    step("ib");
    step("ib");
    check("ib_early_out", 32'(out_pins), 32'h00);
    step("ib");
    check("ib_t3_out", 32'(out_pins), 32'hA5);
    check("ib_t3_st", 32'(sit_raddr), 32'd1);
    step("ib");
    check("ib_t4_out", 32'(out_pins), 32'h5A);
    step("ib");
    check("ib_t5_st", 32'(sit_raddr), 32'd1);

    // Counter match, with an en=0 hold window in the middle.
    setup();
    sit[0] = ent(4'd0, 1'b0, 1'b1, 3'd2, 3'd0, 8'h81, 8'h18, 1'b1, 1'b1, 16'd5, 1'b1);
    sit[2] = ent(4'd0, 1'b0, 1'b0, 3'd2, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    restart_pulse();
    for (int i = 0; i < 3; i++) step("cm");
    check("cm_cnt3", 32'(count_out), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_pins = 16'($urandom);
      sit[1] = ent(4'($urandom), 1'b1, 1'b0, 3'd1, 3'd1, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd0, 1'b1);
      step("hold");
    end
    check("hold_cnt", 32'(count_out), 32'd3);
    check("hold_st", 32'(sit_raddr), 32'd0);
    check("hold_irq", 32'(irq), 32'd0);
    en = 1'b1;
    step("cm");
    step("cm");
    check("cm_cnt5", 32'(count_out), 32'd5);
    check("cm_irq_pre", 32'(irq), 32'd0);
    step("cm");
    check("cm_irq", 32'(irq), 32'd1);
    check("cm_st", 32'(sit_raddr), 32'd2);
    check("cm_clr", 32'(count_out), 32'd0);
    step("cm");
    check("cm_irq_pulse", 32'(irq), 32'd0);

    // Out-of-range next state.
    setup();
    sit[0] = ent(4'd0, 1'b1, 1'b0, 3'd4, 3'd0, 8'h11, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    sit[4] = ent(4'd0, 1'b1, 1'b0, 3'd6, 3'd0, 8'h22, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0);
    restart_pulse();
    step("oor");
    check("oor_st4", 32'(sit_raddr), 32'd4);
    step("oor");
    check("oor_st0", 32'(sit_raddr), 32'd0);
    check("oor_out", 32'(out_pins), 32'h22);

    // Priority: restart and rst while in state 3 with count 7.
    setup();
    sit[0] = ent(4'd0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 16'd0, 1'b0);
    sit[3] = ent(4'd0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h77, 8'h00, 1'b0, 1'b1, 16'd0, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      restart_pulse();
      for (int i = 0; i < 7; i++) step("pri");
      check("pri_pre_st", 32'(sit_raddr), 32'd3);
      check("pri_pre_cnt", 32'(count_out), 32'd7);
      check("pri_pre_irq", 32'(irq), 32'd1);
      restart = 1'b1;
      en = 1'b1;
      if (pass == 1) rst = 1'b1;
      step("pri_hit");
      check("pri_st", 32'(sit_raddr), 32'd0);
      check("pri_cnt", 32'(count_out), 32'd0);
      check("pri_out", 32'(out_pins), 32'd0);
      check("pri_irq", 32'(irq), 32'd0);
      restart = 1'b0;
      rst = 1'b0;
      en = 1'b0;
    end

    // Saturation on a self-looping state.
    setup();
    sit[0] = ent(4'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 16'd0, 1'b0);
    restart_pulse();
    for (int i = 0; i < 65535; i++) step("sat");
    check("sat_top", 32'(count_out), 32'hFFFF);
    for (int i = 0; i < 3; i++) step("sat");
    check("sat_hold", 32'(count_out), 32'hFFFF);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      logic [79:0] e;
      if ($urandom_range(0, 3) == 0) begin
        e = {16'($urandom), $urandom, $urandom};
        e[45:30] = 16'($urandom_range(0, 12));
        sit[$urandom_range(0, 7)] = e;
      end
      in_pins = 16'($urandom);
      en      = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prism_state_engine.md
Name: prism_state_engine

Overview:
- Execution stage directly downstream of the PRISM latch-based State Information Table (SIT).
- Holds the current state index and drives it as the SIT read address.
- Each enabled cycle it decodes the returned SIT entry, evaluates one condition from synchronized inputs or an internal counter, and registers the next state, output pins, counter and interrupt.
- Sits between the SIT and the tinyQV peripheral pin and interrupt logic.

Parameters:
- WIDTH, 80: SIT entry width; must be ≥ 47.
- DEPTH, 8: number of SIT states; legal range 2..8.
- A_BITS, 3: state index width; clog2(DEPTH), minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable (level); host holds low while the SIT is programmed
- restart  in  1  one-cycle pulse: return to state 0
- in_pins  in  16  asynchronous condition inputs
- sit_raddr  out  A_BITS  SIT read address (= current state)
- sit_rdata  in  WIDTH  SIT entry, combinational read of sit_raddr
- out_pins  out  8  registered state-machine outputs
- irq  out  1  one-cycle interrupt pulse
- count_out  out  16  current counter value (debug readback)

Behaviour:
- SIT entry fields, LSB first:
  - [3:0] cond_sel
  - [4] cond_inv
  - [5] cond_cnt
  - [8:6] next_true
  - [11:9] next_false
  - [19:12] out_true
  - [27:20] out_false
  - [28] cnt_clr
  - [29] cnt_inc
  - [45:30] cnt_match
  - [46] irq_en
  - Bits ≥ 47 are ignored.
- Input sync: in_pins pass through a 2-flop synchronizer (in_s). Both stages reset to 0.
- Condition:
  - raw = cond_cnt ? (count == cnt_match) : in_s[cond_sel].
  - cond = raw ^ cond_inv.
- Next-state select: nxt = cond ? next_true : next_false, truncated to A_BITS. If nxt ≥ DEPTH, the next state is 0.
- Each clock edge with en=1, restart=0, rst=0:
  - state <= nxt.
  - out_pins <= cond ? out_true : out_false.
  - Counter: if nxt ≠ state and cnt_clr=1, count <= 0. Else if cnt_inc=1, count <= count+1, saturating at 16'hFFFF (no wrap). Else count holds.
  - A self-loop (nxt == state) never clears the counter.
  - irq <= cond & irq_en. It is a pulse, high for exactly one cycle per qualifying evaluation; consecutive qualifying cycles give irq held high.
- en=0: state, out_pins and count hold; irq <= 0; the synchronizer keeps running.
- Priority: rst > restart > en.
  - restart=1 (any en): state <= 0, count <= 0, out_pins <= 0, irq <= 0.
- Reset values: state=0 (sit_raddr=0), out_pins=0, irq=0, count_out=0, synchronizer 0.
- Reset or restart mid-run aborts the evaluation in that cycle; nothing from the current entry is committed.
- Latency:
  - in_pins change to evaluation: 2 cycles.
  - Evaluation to out_pins/irq/state update: 1 cycle.
  - Total: the 3rd rising edge after the input change.
- sit_raddr = state register, purely registered. The SIT read is combinational, so one state transition per cycle is sustained.
- sit_rdata may change while en=0 (reprogramming); it is only sampled when en=1.
- No other state. All logic is in the clk domain only.

Test Plan:
- Reset/idle: assert rst 2 cycles with en=1, random in_pins → sit_raddr=0, out_pins=0, irq=0, count_out=0 through reset and on the first cycle after.
- Input branch:
  - Setup: state0 {cond_sel=3, next_true=1, next_false=0, out_true=8'hA5, out_false=8'h00}; state1 {cond_sel=3, cond_inv=1, next_true=0, next_false=1, out_true=8'h3C, out_false=8'h5A}.
  - Stimulus: raise in_pins[3] at edge T.
  - Response: out_pins=A5 and sit_raddr=1 after edge T+3; then out_pins=5A while in_pins[3] stays high.
- Counter match:
  - Setup: state0 {cond_cnt=1, cnt_match=5, cnt_inc=1, cnt_clr=1, next_true=2, next_false=0, irq_en=1}.
  - Response: count_out steps 1..5, irq pulses exactly one cycle, sit_raddr=2, count cleared to 0 on that transition.
- Saturation: self-looping state with cnt_inc=1, cnt_clr=1, match never reached → count_out stops at 16'hFFFF and never wraps or clears.
- Out-of-range and hold:
  - DEPTH=5 with next_true=6 → state becomes 0.
  - en=0 for 10 cycles → state, out_pins and count_out unchanged; irq=0.
- Priority: restart and en high together while in state 3 with count=7 → next cycle sit_raddr=0, count_out=0, out_pins=0, irq=0. rst together with restart behaves identically.
